// File: rtl/render_scheduler.sv
// render_scheduler: sequences one render pass per frame through the 3D datapath.
// On new_frame_in it issues facet indices 0..NUM_FACETS-1 to the vertex fetch /
// transform front end over a ready/valid handshake. A credit counter bounds the
// number of in-flight triangles, and completions from the projection stage are
// counted so obj_done_out pulses once the whole object has drained.
//
// Optional feature: define RENDER_SCHED_STATS_EN to add frame_cycles_out, the
// cycle count from frame acceptance to obj_done_out for the last completed pass.
//
// Ports:
//   clk_in           pixel clock
//   rst_in           asynchronous active-high reset
//   new_frame_in     one-cycle start-of-frame pulse
//   issue_valid_out  tri_idx_out is valid
//   issue_ready_in   front end accepts the index this cycle
//   tri_idx_out      facet index being issued
//   done_in          one pulse per triangle leaving projection
//   obj_done_out     one-cycle pulse when all facets have completed
//   busy_out         render pass in progress
//   inflight_out     current credit usage
//   overrun_out      saturating count of frames dropped while busy
//   err_out          sticky: done_in seen with no triangle in flight
//   frame_cycles_out (RENDER_SCHED_STATS_EN only) last pass length in cycles
module render_scheduler #(
  parameter int unsigned NUM_FACETS   = 12,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned IDX_W        = (NUM_FACETS > 1) ? $clog2(NUM_FACETS) : 1,
  localparam int unsigned CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             new_frame_in,
  output logic             issue_valid_out,
  input  logic             issue_ready_in,
  output logic [IDX_W-1:0] tri_idx_out,
  input  logic             done_in,
  output logic             obj_done_out,
  output logic             busy_out,
  output logic [CW-1:0]    inflight_out,
  output logic [7:0]       overrun_out,
`ifdef RENDER_SCHED_STATS_EN
  output logic [19:0]      frame_cycles_out,
`endif
  output logic             err_out
);

  localparam int unsigned NW = $clog2(NUM_FACETS + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] tri_idx_q, tri_idx_d;
  logic             valid_q, valid_d;
  logic             obj_done_q, obj_done_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [NW-1:0]    done_cnt_q, done_cnt_d;
  logic [7:0]       overrun_q, overrun_d;
  logic             err_q, err_d;
  logic             xfer, active, done_ok, start;

  always_comb begin
    state_d    = state_q;
    tri_idx_d  = tri_idx_q;
    inflight_d = inflight_q;
    done_cnt_d = done_cnt_q;
    overrun_d  = overrun_q;
    err_d      = err_q;
    start      = 1'b0;

    xfer    = valid_q && issue_ready_in;
    active  = (state_q == StIssue) || (state_q == StDrain);
    // Completions are only accepted against an outstanding credit.
    done_ok = done_in && active && (inflight_q != '0);

    if (done_in && (inflight_q == '0)) err_d = 1'b1;

    if (xfer && !done_ok)      inflight_d = inflight_q + 1'b1;
    else if (!xfer && done_ok) inflight_d = inflight_q - 1'b1;

    if (done_ok) done_cnt_d = done_cnt_q + 1'b1;

    if (new_frame_in && active && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;

    unique case (state_q)
      StIdle:  if (new_frame_in) start = 1'b1;
      StIssue: begin
        if (xfer) begin
          if (tri_idx_q == IDX_W'(NUM_FACETS - 1)) state_d = StDrain;
          else                                     tri_idx_d = tri_idx_q + 1'b1;
        end
      end
      StDrain: if (done_cnt_d == NW'(NUM_FACETS)) state_d = StDone;
      StDone: begin
        if (new_frame_in) start = 1'b1;
        else              state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d    = StIssue;
      tri_idx_d  = '0;
      done_cnt_d = '0;
    end

    // Credit check uses next-cycle usage so a freed credit re-enables valid at once,
    // and valid is never dropped without a transfer unless credits run out.
    valid_d    = (state_d == StIssue) && (inflight_d < CW'(MAX_INFLIGHT));
    obj_done_d = (state_d == StDone);
    busy_d     = (state_d == StIssue) || (state_d == StDrain);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      tri_idx_q  <= '0;
      valid_q    <= 1'b0;
      obj_done_q <= 1'b0;
      busy_q     <= 1'b0;
      inflight_q <= '0;
      done_cnt_q <= '0;
      overrun_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tri_idx_q  <= tri_idx_d;
      valid_q    <= valid_d;
      obj_done_q <= obj_done_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      done_cnt_q <= done_cnt_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  assign issue_valid_out = valid_q;
  assign tri_idx_out     = tri_idx_q;
  assign obj_done_out    = obj_done_q;
  assign busy_out        = busy_q;
  assign inflight_out    = inflight_q;
  assign overrun_out     = overrun_q;
  assign err_out         = err_q;

`ifdef RENDER_SCHED_STATS_EN
  logic [19:0] cyc_q, cyc_d;
  logic [19:0] frame_cycles_q, frame_cycles_d;

  always_comb begin
    cyc_d          = cyc_q;
    frame_cycles_d = frame_cycles_q;
    // cyc_q equals cycles since acceptance on the edge that enters StDone.
    if (start)                        cyc_d = 20'd1;
    else if (active && cyc_q != '1)   cyc_d = cyc_q + 20'd1;
    if ((state_d == StDone) && !start) frame_cycles_d = cyc_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_q          <= '0;
      frame_cycles_q <= '0;
    end else begin
      cyc_q          <= cyc_d;
      frame_cycles_q <= frame_cycles_d;
    end
  end

  assign frame_cycles_out = frame_cycles_q;
`endif

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
- Sequences one render pass per video frame through the 3D datapath: vertex fetch -> transformation -> triangle projection -> rasterizer.
- On new_frame_in it issues facet indices 0..NUM_FACETS-1 to the vertex fetch/transform front end under a ready/valid handshake.
- Bounds in-flight triangles with a credit counter so the inter-stage FIFO can never overflow.
- Counts completions from the projection stage and pulses obj_done_out to the rasterizer when the whole object has drained.

Parameters:
- NUM_FACETS, 12, triangles per object; legal range >= 1.
- MAX_INFLIGHT, 4, maximum issued-but-not-completed triangles; must not exceed the FIFO depth.
- IDX_W, $clog2(NUM_FACETS) (minimum 1), width of the facet index.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  reset, asynchronous, active-high.
- new_frame_in  input  1  one-cycle pulse at start of frame.
- issue_valid_out  output  1  facet index on tri_idx_out is valid.
- issue_ready_in  input  1  front end accepts the index this cycle.
- tri_idx_out  output  IDX_W  facet index being issued.
- done_in  input  1  one-cycle pulse per triangle leaving the projection stage.
- obj_done_out  output  1  one-cycle pulse when all facets of the frame have completed.
- busy_out  output  1  render pass in progress.
- inflight_out  output  $clog2(MAX_INFLIGHT+1)  current credit usage.
- overrun_out  output  8  saturating count of frames skipped because the previous pass was still busy.
- err_out  output  1  sticky flag; set by done_in while inflight==0.

Behaviour:
- All outputs are registered.
- Reset values: issue_valid_out=0, tri_idx_out=0, obj_done_out=0, busy_out=0, inflight_out=0, overrun_out=0, err_out=0, state=IDLE.
- Reset asserted mid-pass aborts immediately; there is no residual obj_done_out pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On new_frame_in go to ISSUE next cycle; tri_idx_out=0, busy_out=1, issued count=0, completed count=0.
  - The first issue_valid_out=1 appears 1 cycle after the pulse.
- ISSUE:
  - issue_valid_out=1 whenever inflight < MAX_INFLIGHT.
  - Transfer occurs when issue_valid_out && issue_ready_in. On transfer: tri_idx_out increments and inflight increments.
  - tri_idx_out stays stable while valid and not ready. Valid is never withdrawn without a transfer, except at credit exhaustion, which is checked before valid is raised.
  - After the transfer of index NUM_FACETS-1: issue_valid_out=0 next cycle, go to DRAIN.
- DRAIN: stay until completed count == NUM_FACETS, then go to DONE.
- DONE: obj_done_out=1 for exactly one cycle, busy_out=0, go to IDLE. A new_frame_in arriving in DONE is accepted as a new frame (go to ISSUE).
- Credit arithmetic:
  - inflight +1 on transfer, -1 on done_in; simultaneous transfer and done_in leaves it unchanged.
  - A done_in in the same cycle that frees the last credit allows issue_valid_out=1 the following cycle.
- done_in rules:
  - done_in counts only in ISSUE or DRAIN.
  - done_in with inflight==0 is ignored (no underflow, no completed-count change) and sets err_out.
- Overrun: new_frame_in in ISSUE or DRAIN is dropped; the current pass continues and overrun_out increments, saturating at 255.
- Latency:
  - Minimum pass with issue_ready_in held 1 and done_in returning D cycles after each issue: roughly NUM_FACETS+D+2 cycles from new_frame_in to obj_done_out.
  - The issue rate is limited to MAX_INFLIGHT per D cycles when D > MAX_INFLIGHT.

Optional Feature:
- Macro: RENDER_SCHED_STATS_EN.
- Defined: adds output frame_cycles_out [19:0], holding the clk_in cycle count from accepting new_frame_in to obj_done_out for the last completed pass.
  - It updates in the cycle obj_done_out is asserted.
  - It saturates at 20'hFFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then a single new_frame_in with ready=1 and done_in 3 cycles after each issue -> indices 0..11 issued in order, obj_done_out pulses once, busy_out falls the same cycle, inflight_out returns to 0.
- ready=1, done_in withheld -> exactly 4 transfers (idx 0..3), then issue_valid_out=0 and inflight_out=4. One done_in pulse -> exactly one more transfer (idx 4).
- issue_ready_in low for 5 cycles while valid at idx 2 -> tri_idx_out holds 2 and issue_valid_out holds 1; no index is skipped after ready returns.
- new_frame_in pulsed twice during DRAIN -> overrun_out=2, no restart, a single obj_done_out. The next new_frame_in in IDLE starts a fresh pass at idx 0.
- done_in pulsed in IDLE -> err_out=1 (sticky), inflight_out stays 0. A transfer and a done_in in the same cycle with inflight=3 -> inflight stays 3.
- rst_in asserted mid-ISSUE at idx 6, asynchronously between clock edges -> all outputs are 0 immediately and no obj_done_out follows. With RENDER_SCHED_STATS_EN and the 3-cycle done_in return, frame_cycles_out equals the measured pulse-to-done distance.
